// File: rtl/itoh_pkg.sv
// rtl/itoh_pkg.sv - shared types and constants for the GF(2^8) Itoh-Tsuji inverter
// Contents:
//   state_t   FSM state encoding (IDLE, S2..S6, DONE)
//   POLY_RED  low byte of the field polynomial 0x11B (x^8 term implicit)
//   SEL_*     squarer power-select codes
//   ONE       multiplicative identity used on the final squaring step
package itoh_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      S2   = 3'd1,
      S3   = 3'd2,
      S4   = 3'd3,
      S5   = 3'd4,
      S6   = 3'd5,
      DONE = 3'd6
   } state_t;

   localparam logic [7:0] POLY_RED = 8'h1B;

   localparam logic [1:0] SEL_NONE = 2'b00;
   localparam logic [1:0] SEL_SQ1  = 2'b01;
   localparam logic [1:0] SEL_SQ3  = 2'b11;

   localparam logic [7:0] ONE = 8'h01;

endpackage

// File: rtl/itoh_tsuji_ctrl_gf_mult.sv
// rtl/itoh_tsuji_ctrl_gf_mult.sv - combinational GF(2^8) multiplier modulo 0x11B
// Ports:
//   a, b  input  8  operands
//   p     output 8  a*b reduced by the field polynomial
module gf_mult
   import itoh_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] p
);

   logic [7:0] acc;
   logic [7:0] sh;

   // Shift-and-add: sh walks through a*x^i (already reduced), acc collects
   // the terms selected by the bits of b.
   always_comb begin
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) begin
            acc = acc ^ sh;
         end
         sh = {sh[6:0], 1'b0} ^ (sh[7] ? POLY_RED : 8'h00);
      end
      p = acc;
   end

endmodule

// File: rtl/itoh_tsuji_ctrl.sv
// rtl/itoh_tsuji_ctrl.sv - sequential Itoh-Tsuji inverter for GF(2^8), chain 1-2-3-6-7 plus final square
// Optional feature macro: ITOH_ZERO_DETECT_EN (adds zero_err, zero operand short-cuts to DONE)
// Ports:
//   clk      input  1  clock, rising edge
//   rst      input  1  synchronous active-high reset
//   start    input  1  launch an inversion (accepted in IDLE only)
//   a_in     input  8  operand, captured on the accepted start
//   busy     output 1  high while the chain runs (S2..S6)
//   done     output 1  one-cycle completion pulse
//   inv_out  output 8  a^-1 (inv(0)=0), holds until the next result
//   sq_din   output 8  to external squarer, the working register t
//   sq_sel   output 2  to external squarer, 01=x^2, 11=x^8, 00 when idle
//   sq_dout  input  8  from external squarer, combinational
//   zero_err output 1  (ITOH_ZERO_DETECT_EN only) pulses with done for a zero operand
module itoh_tsuji_ctrl
   import itoh_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] a_in,
   output logic       busy,
   output logic       done,
   output logic [7:0] inv_out,
   output logic [7:0] sq_din,
   output logic [1:0] sq_sel,
   input  logic [7:0] sq_dout
`ifdef ITOH_ZERO_DETECT_EN
   ,
   output logic       zero_err
`endif
);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] a_r;
   logic [7:0] t;
   logic [7:0] b3;
   logic [7:0] m_op;
   logic [7:0] prod;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
`ifdef ITOH_ZERO_DETECT_EN
               state_nxt = (a_in == 8'h00) ? DONE : S2;
`else
               state_nxt = S2;
`endif
            end
         end
         S2:      state_nxt = S3;
         S3:      state_nxt = S4;
         S4:      state_nxt = S5;
         S5:      state_nxt = S6;
         S6:      state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- output / operand decode ----------------
   // S4 raises beta3 to x^8 and multiplies by the saved beta3 (3+3=6);
   // every other chain step squares once and multiplies by a (k -> k+1),
   // except S6, whose multiplicand is 1 to give the plain final square.
   always_comb begin
      sq_sel = SEL_NONE;
      m_op   = ONE;
      busy   = 1'b0;
      done   = 1'b0;
      case (state)
         S2, S3, S5: begin
            sq_sel = SEL_SQ1;
            m_op   = a_r;
            busy   = 1'b1;
         end
         S4: begin
            sq_sel = SEL_SQ3;
            m_op   = b3;
            busy   = 1'b1;
         end
         S6: begin
            sq_sel = SEL_SQ1;
            m_op   = ONE;
            busy   = 1'b1;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
            sq_sel = SEL_NONE;
         end
      endcase
   end

   // ---------------- step datapath ----------------
   gf_mult u_gf_mult (
      .a (sq_dout),
      .b (m_op),
      .p (prod)
   );

   assign sq_din = t;

   always_ff @(posedge clk) begin
      if (rst) begin
         a_r     <= 8'h00;
         t       <= 8'h00;
         b3      <= 8'h00;
         inv_out <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_r <= a_in;
                  t   <= a_in;
`ifdef ITOH_ZERO_DETECT_EN
                  if (a_in == 8'h00) begin
                     inv_out <= 8'h00;
                  end
`endif
               end
            end
            S2, S4, S5: begin
               t <= prod;
            end
            S3: begin
               t  <= prod;
               b3 <= prod;
            end
            S6: begin
               t       <= prod;
               inv_out <= prod;
            end
            default: begin
               t <= t;
            end
         endcase
      end
   end

`ifdef ITOH_ZERO_DETECT_EN
   // Registered on the accepting edge, so it lines up with the DONE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         zero_err <= 1'b0;
      end else begin
         zero_err <= (state == IDLE) && start && (a_in == 8'h00);
      end
   end
`endif

endmodule

// File: tb/tb_itoh_tsuji_ctrl.sv
// tb/tb_itoh_tsuji_ctrl.sv - self-checking bench for itoh_tsuji_ctrl with a behavioural cascaded squarer
module tb_itoh_tsuji_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a_in;
   logic       busy;
   logic       done;
   logic [7:0] inv_out;
   logic [7:0] sq_din;
   logic [1:0] sq_sel;
   logic [7:0] sq_dout;
`ifdef ITOH_ZERO_DETECT_EN
   logic       zero_err;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   itoh_tsuji_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a_in     (a_in),
      .busy     (busy),
      .done     (done),
      .inv_out  (inv_out),
      .sq_din   (sq_din),
      .sq_sel   (sq_sel),
      .sq_dout  (sq_dout)
`ifdef ITOH_ZERO_DETECT_EN
      ,
      .zero_err (zero_err)
`endif
   );

   function automatic logic [7:0] xt(input logic [7:0] v);
      return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
   endfunction

   // Horner-form multiply, MSB of b first
   function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         r = xt(r);
         if (b[i]) r = r ^ a;
      end
      return r;
   endfunction

   function automatic logic [7:0] sq_model(input logic [7:0] d, input logic [1:0] sel);
      logic [7:0] s;
      case (sel)
         2'b01:   s = mul(d, d);
         2'b11: begin
            s = mul(d, d);
            s = mul(s, s);
            s = mul(s, s);
         end
         default: s = d;
      endcase
      return s;
   endfunction

   assign sq_dout = sq_model(sq_din, sq_sel);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Called #1 after an edge; returns #1 after the edge that enters DONE.
   task automatic run_op(input logic [7:0] a, output logic [7:0] res,
                         output int lat, output int bcnt);
      start = 1'b1;
      a_in  = a;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 99;
      bcnt  = 0;
      for (int k = 1; k <= 20; k++) begin
         if (busy) bcnt++;
         if (done) begin
            lat = k;
            break;
         end
         @(posedge clk);
         #1;
      end
      res = inv_out;
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] inv;
      int         lat;
      int         bc;
   } vec_t;

   vec_t vecs[5];

   logic [7:0] res;
   int         lat;
   int         bc;
   logic [1:0] sel_exp[5];

   initial begin
      vecs[0] = '{8'h53, 8'hCA, 6, 5};
      vecs[1] = '{8'h01, 8'h01, 6, 5};
      vecs[2] = '{8'h02, 8'h8D, 6, 5};
      vecs[3] = '{8'h03, 8'hF6, 6, 5};
`ifdef ITOH_ZERO_DETECT_EN
      vecs[4] = '{8'h00, 8'h00, 1, 0};
`else
      vecs[4] = '{8'h00, 8'h00, 6, 5};
`endif
      sel_exp[0] = 2'b01;
      sel_exp[1] = 2'b01;
      sel_exp[2] = 2'b11;
      sel_exp[3] = 2'b01;
      sel_exp[4] = 2'b01;

      rst   = 1'b1;
      start = 1'b0;
      a_in  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_inv", inv_out, 0);
      chk("rst_sq_din", sq_din, 0);
      chk("rst_sq_sel", sq_sel, 0);
`ifdef ITOH_ZERO_DETECT_EN
      chk("rst_zero_err", zero_err, 0);
`endif
      rst = 1'b0;
      @(posedge clk);
      #1;

      // table-driven vectors
      for (int v = 0; v < 5; v++) begin
         run_op(vecs[v].a, res, lat, bc);
         chk($sformatf("vec%0d_inv", v), res, vecs[v].inv);
         chk($sformatf("vec%0d_lat", v), lat, vecs[v].lat);
         chk($sformatf("vec%0d_busy", v), bc, vecs[v].bc);
`ifdef ITOH_ZERO_DETECT_EN
         chk($sformatf("vec%0d_zero_err", v), zero_err, (vecs[v].a == 8'h00) ? 1 : 0);
`endif
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_idle_done", v), done, 0);
      end

      // exhaustive product check
      for (int a = 1; a < 256; a++) begin
         run_op(a[7:0], res, lat, bc);
         chk($sformatf("sweep_%0h", a), {lat[7:0], mul(a[7:0], res)}, {8'd6, 8'h01});
         @(posedge clk);
         #1;
      end

      // start pulsed in S3 is ignored; also check squarer selects along the chain
      start = 1'b1;
      a_in  = 8'h53;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat   = 99;
      for (int k = 1; k <= 20; k++) begin
         start = (k == 2);
         a_in  = (k == 2) ? 8'h02 : 8'h53;
         if (k == 1) chk("ign_sq_din_s2", sq_din, 8'h53);
         if (k <= 5) chk($sformatf("ign_sel_k%0d", k), sq_sel, sel_exp[k-1]);
         if (done) begin
            lat = k;
            break;
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      chk("ign_lat", lat, 6);
      chk("ign_inv", inv_out, 8'hCA);
      chk("ign_sel_done", sq_sel, 0);

      // start sampled in DONE is ignored
      start = 1'b1;
      a_in  = 8'h02;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("done_start_busy", busy, 0);
      chk("done_start_done", done, 0);
      @(posedge clk);
      #1;
      chk("done_start_busy2", busy, 0);
      chk("done_start_inv", inv_out, 8'hCA);

      // reset in S4
      start = 1'b1;
      a_in  = 8'h53;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("pre_rst_sel_s4", sq_sel, 2'b11);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_inv", inv_out, 0);
      chk("mid_rst_sel", sq_sel, 0);
      chk("mid_rst_din", sq_din, 0);
      @(posedge clk);
      #1;
      chk("mid_rst_idle", busy, 0);
      run_op(8'h53, res, lat, bc);
      chk("post_rst_inv", res, 8'hCA);
      chk("post_rst_lat", lat, 6);
      @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/itoh_tsuji_ctrl.md
# itoh_tsuji_ctrl

Sequential Itoh-Tsuji inverter for GF(2^8) with field polynomial x^8+x^4+x^3+x+1 (0x11B). It runs the addition chain 1→2→3→6→7 and then a final squaring. Each cycle it drives the external 3-stage cascaded squarer with the working value and a power select, multiplies the squarer's output by a stored operand, and writes the product back. The block sits directly upstream and downstream of the cascaded squarer, and top level wires the two together.

## Interface
- No parameters. Field width is fixed at 8 and the polynomial is fixed at 0x11B, because the squarer is hard-wired to this polynomial.
- clk  input  1  sole clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  sampled in IDLE only; launches an inversion of a_in.
- a_in  input  8  operand, captured on the accepted start.
- busy  output  1  high from the cycle after the accepted start until done.
- done  output  1  one-cycle pulse; inv_out is valid from this cycle on.
- inv_out  output  8  a^-1; inv(0)=0. Holds until the next accepted start.
- sq_din  output  8  to squarer din; equals the working register t.
- sq_sel  output  2  to squarer select: 01=x^2, 11=x^8. Code 00 is driven only when the block is not computing.
- sq_dout  input  8  from squarer dout; combinational, used in the same cycle.

## Operation
- Registers: a_r (operand), t (working value), b3 (saved a^(2^3-1)), state.
- The step datapath is: t ← gf_mult(sq_dout, m_op).
- FSM states are IDLE, S2, S3, S4, S5, S6, DONE.
- IDLE: sq_sel=00. On start, a_r←a_in, t←a_in, go to S2. If start is low, stay in IDLE.
- S2: sel=01, m_op=a_r; t becomes a^3 (β2). Go to S3.
- S3: sel=01, m_op=a_r; t becomes β3=a^7. b3 is loaded with the same product. Go to S4.
- S4: sel=11, m_op=b3; t becomes β6=a^63. Go to S5.
- S5: sel=01, m_op=a_r; t becomes β7=a^127. Go to S6.
- S6: sel=01, m_op=8'h01; t becomes a^254=a^-1. inv_out←product. Go to DONE.
- DONE: done=1, busy=0, sq_sel=00. Return to IDLE.
- Zero input: the chain yields 0 naturally, and no special handling is required.
- start in any state other than IDLE is ignored, with no queuing.
- start sampled in DONE is ignored. A new start is accepted only in IDLE.
- rst at any point, including mid-chain: next state is IDLE. busy, done and inv_out go to 0, sq_sel to 00, and a_r, t and b3 clear to 0.
- gf_mult: carry-less 8×8 product reduced modulo 0x11B, fully combinational.

## Timing
- Call the edge that samples start in IDLE edge 0.
- busy is high during S2..S6, which is 5 cycles after edge 0.
- done is high in the 6th cycle after edge 0. Start-to-done latency is 6 clocks.
- Back-to-back operation: minimum start-to-start spacing is 7 cycles (IDLE→S2..S6→DONE→IDLE).
- Critical path: t register → squarer (3 stages) → gf_mult → t.
- All outputs are registered or decoded from state, except sq_din. sq_din is t itself, which is also a register.
- Reset values: busy=0, done=0, inv_out=8'h00, sq_din=8'h00, sq_sel=2'b00.

## Configuration
- Macro: ITOH_ZERO_DETECT_EN.
- Defined:
  - Adds the output port zero_err (1 bit), which resets to 0.
  - A start with a_in==0 goes from IDLE straight to DONE. In that case done and zero_err pulse together one cycle after edge 0, and inv_out=0.
  - zero_err is 0 for every non-zero operand.
- Undefined:
  - The zero_err port is absent.
  - a_in=0 runs the full 6-cycle chain and gives inv_out=0.

## Structure
- Package itoh_pkg holds:
  - the state enum;
  - POLY_RED = 8'h1B;
  - SEL_NONE/SEL_SQ1/SEL_SQ3 = 2'b00/01/11;
  - ONE = 8'h01.
- Sub-module gf_mult (combinational 8-bit GF(2^8) multiplier, reduction by POLY_RED), instantiated once.
- The squarer is not instantiated inside this block; it is connected through the sq_* ports.

## Test plan
- a_in=8'h53, start → done exactly 6 clocks later with inv_out=8'hCA. busy is high for 5 cycles.
- a_in=8'h01 → inv_out=8'h01; a_in=8'h02 → inv_out=8'h8D.
- Exhaustive sweep of a_in=1..255: for each, gf_mult(a_in, inv_out)==8'h01.
- Pulse start again at S3 with a different a_in → it is ignored, and the original result is delivered on schedule.
- Assert rst during S4 → next cycle IDLE, all outputs 0. A fresh start with 8'h53 then returns 8'hCA.
- a_in=8'h00:
  - With ITOH_ZERO_DETECT_EN: done and zero_err at edge 0+1, inv_out=0.
  - Without it: done at 6 clocks, inv_out=0.
